butterfly_radix2: RTL and testbench

- Pipelined radix-2 decimation-in-frequency (DIF) butterfly for the multimode FFT datapath. Arithmetic is complex, signed fixed-point Q1.15 at the default width.
- Computes y0 = x0 + x1 and y1 = (x0 − x1)·W, where W is the twiddle factor.
- Sits between the stage data memory and the twiddle ROM inside each FFT stage.
- Accepts one butterfly per cycle, with a fixed 2-stage latency and a valid strobe on the output.

---
 rtl/butterfly_radix2_if.sv | 30 +++
 rtl/butterfly_radix2.sv | 127 ++++++++++++
 tb/tb_butterfly_radix2.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/butterfly_radix2_if.sv
// Operand/twiddle inputs and result outputs of the radix-2 butterfly.
// The master side drives operands; the slave side is the butterfly itself.
interface butterfly_radix2_if #(
  parameter int unsigned WIDTH = 16
);

  logic                    enable;
  logic signed [WIDTH-1:0] x0_real;
  logic signed [WIDTH-1:0] x0_imag;
  logic signed [WIDTH-1:0] x1_real;
  logic signed [WIDTH-1:0] x1_imag;
  logic signed [WIDTH-1:0] tw_real;
  logic signed [WIDTH-1:0] tw_imag;
  logic signed [WIDTH-1:0] y0_real;
  logic signed [WIDTH-1:0] y0_imag;
  logic signed [WIDTH-1:0] y1_real;
  logic signed [WIDTH-1:0] y1_imag;
  logic                    valid;

  modport master (
    output enable, x0_real, x0_imag, x1_real, x1_imag, tw_real, tw_imag,
    input  y0_real, y0_imag, y1_real, y1_imag, valid
  );

  modport slave (
    input  enable, x0_real, x0_imag, x1_real, x1_imag, tw_real, tw_imag,
    output y0_real, y0_imag, y1_real, y1_imag, valid
  );

endinterface

// File: rtl/butterfly_radix2.sv
// Two-stage pipelined radix-2 DIF butterfly: y0 = x0 + x1, y1 = (x0 - x1) * W.
// Q1.(WIDTH-1) complex arithmetic with silent saturation and half-up rounding.
module butterfly_radix2 #(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  butterfly_radix2_if.slave bus
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH + 2;
  localparam int unsigned SH = WIDTH - 1;

  localparam logic signed [PW-1:0] SAT_MAX = PW'({1'b0, {(WIDTH - 1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [PW-1:0] RND     = PW'(1) << (WIDTH - 2);

  // Clamp a wide signed value into the WIDTH-bit output range.
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [WIDTH-1:0] r;
    r = v[WIDTH-1:0];
    if (v > SAT_MAX) begin
      r = {1'b0, {(WIDTH - 1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(WIDTH - 1){1'b0}}};
    end
    return r;
  endfunction

  logic signed [DW-1:0] sum_real;
  logic signed [DW-1:0] sum_imag;
  logic signed [DW-1:0] diff_real;
  logic signed [DW-1:0] diff_imag;

  // Pre-stage: one guard bit so neither the sum nor the difference can wrap.
  always_comb begin
    sum_real  = DW'(bus.x0_real) + DW'(bus.x1_real);
    sum_imag  = DW'(bus.x0_imag) + DW'(bus.x1_imag);
    diff_real = DW'(bus.x0_real) - DW'(bus.x1_real);
    diff_imag = DW'(bus.x0_imag) - DW'(bus.x1_imag);
  end

  logic                    v1;
  logic signed [WIDTH-1:0] s1_sum_real;
  logic signed [WIDTH-1:0] s1_sum_imag;
  logic signed [DW-1:0]    s1_diff_real;
  logic signed [DW-1:0]    s1_diff_imag;
  logic signed [WIDTH-1:0] s1_tw_real;
  logic signed [WIDTH-1:0] s1_tw_imag;

  // Stage 1: the sum is saturated here, the difference keeps its guard bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1           <= 1'b0;
      s1_sum_real  <= '0;
      s1_sum_imag  <= '0;
      s1_diff_real <= '0;
      s1_diff_imag <= '0;
      s1_tw_real   <= '0;
      s1_tw_imag   <= '0;
    end else begin
      v1 <= bus.enable;
      if (bus.enable) begin
        s1_sum_real  <= sat(PW'(sum_real));
        s1_sum_imag  <= sat(PW'(sum_imag));
        s1_diff_real <= diff_real;
        s1_diff_imag <= diff_imag;
        s1_tw_real   <= bus.tw_real;
        s1_tw_imag   <= bus.tw_imag;
      end
    end
  end

  logic signed [PW-1:0] dr;
  logic signed [PW-1:0] di;
  logic signed [PW-1:0] wr;
  logic signed [PW-1:0] wi;
  logic signed [PW-1:0] pr_full;
  logic signed [PW-1:0] pi_full;
  logic signed [PW-1:0] pr_rnd;
  logic signed [PW-1:0] pi_rnd;

  // Full-precision complex multiply, then round half-up back to Q1.(WIDTH-1).
  always_comb begin
    dr      = PW'(s1_diff_real);
    di      = PW'(s1_diff_imag);
    wr      = PW'(s1_tw_real);
    wi      = PW'(s1_tw_imag);
    pr_full = (dr * wr) - (di * wi);
    pi_full = (dr * wi) + (di * wr);
    pr_rnd  = (pr_full + RND) >>> SH;
    pi_rnd  = (pi_full + RND) >>> SH;
  end

  logic                    valid_q;
  logic signed [WIDTH-1:0] y0_real_q;
  logic signed [WIDTH-1:0] y0_imag_q;
  logic signed [WIDTH-1:0] y1_real_q;
  logic signed [WIDTH-1:0] y1_imag_q;

  // Stage 2: results hold between valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      y0_real_q <= '0;
      y0_imag_q <= '0;
      y1_real_q <= '0;
      y1_imag_q <= '0;
    end else begin
      valid_q <= v1;
      if (v1) begin
        y0_real_q <= s1_sum_real;
        y0_imag_q <= s1_sum_imag;
        y1_real_q <= sat(pr_rnd);
        y1_imag_q <= sat(pi_rnd);
      end
    end
  end

  assign bus.valid   = valid_q;
  assign bus.y0_real = y0_real_q;
  assign bus.y0_imag = y0_imag_q;
  assign bus.y1_real = y1_real_q;
  assign bus.y1_imag = y1_imag_q;

endmodule

// File: tb/tb_butterfly_radix2.sv
// Scoreboard bench for butterfly_radix2: directed corner vectors, a random
// back-to-back burst, output hold and asynchronous reset flush.
module tb_butterfly_radix2;

  localparam int unsigned WIDTH = 16;
  localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (WIDTH - 1));

  typedef struct {
    longint xr0, xi0, xr1, xi1, wr, wi;
  } vec_t;

  typedef struct {
    longint y0r, y0i, y1r, y1i;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  butterfly_radix2_if #(.WIDTH(WIDTH)) bus ();

  butterfly_radix2 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  exp_t last_exp;
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;
  int   sent     = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint satw(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t   e;
    longint dr, di, pr, pi;
    dr    = v.xr0 - v.xr1;
    di    = v.xi0 - v.xi1;
    pr    = dr * v.wr - di * v.wi;
    pi    = dr * v.wi + di * v.wr;
    e.y0r = satw(v.xr0 + v.xr1);
    e.y0i = satw(v.xi0 + v.xi1);
    e.y1r = satw((pr + (64'sd1 <<< (WIDTH - 2))) >>> (WIDTH - 1));
    e.y1i = satw((pi + (64'sd1 <<< (WIDTH - 2))) >>> (WIDTH - 1));
    return e;
  endfunction

  function automatic longint r16();
    logic [WIDTH-1:0] t;
    t = WIDTH'($urandom);
    return longint'($signed(t));
  endfunction

  task automatic apply(input vec_t v);
    bus.x0_real = WIDTH'(v.xr0);
    bus.x0_imag = WIDTH'(v.xi0);
    bus.x1_real = WIDTH'(v.xr1);
    bus.x1_imag = WIDTH'(v.xi1);
    bus.tw_real = WIDTH'(v.wr);
    bus.tw_imag = WIDTH'(v.wi);
  endtask

  task automatic send(input vec_t v, input exp_t e);
    @(negedge clk);
    apply(v);
    bus.enable = 1'b1;
    q.push_back(e);
    sent++;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", longint'(q.size()), 0);
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, "_y0_real"}, longint'(bus.y0_real), e.y0r);
    check({tag, "_y0_imag"}, longint'(bus.y0_imag), e.y0i);
    check({tag, "_y1_real"}, longint'(bus.y1_real), e.y1r);
    check({tag, "_y1_imag"}, longint'(bus.y1_imag), e.y1i);
  endtask

  // Scoreboard: every valid pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (!rst && bus.valid) begin
      pulses++;
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check_outputs("result", mon_e);
        last_exp = mon_e;
      end
    end
  end

  initial begin
    vec_t v;
    exp_t e;
    exp_t zero;

    zero = '{0, 0, 0, 0};
    rst  = 1'b1;
    bus.enable = 1'b0;
    v = '{0, 0, 0, 0, 0, 0};
    apply(v);

    #3;
    check("reset_valid", longint'(bus.valid), 0);
    check_outputs("reset", zero);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Positive sum saturation plus unity-twiddle difference, with latency probe.
    send('{32767, 0, 16384, 0, 32767, 0}, '{32767, 0, 16383, 0});
    @(negedge clk);
    bus.enable = 1'b0;
    check("latency_edge1_valid", longint'(bus.valid), 0);
    @(negedge clk);
    check("latency_edge2_valid", longint'(bus.valid), 1);
    @(negedge clk);
    check("single_pulse_valid", longint'(bus.valid), 0);
    drain();

    send('{16384, 0, 16384, 0, 32767, 0}, '{32767, 0, 0, 0});
    idle();
    drain();

    // Difference of 32768 times j: rounds to the top code.
    send('{16384, 0, -16384, 0, 0, 32767}, '{0, 0, 0, 32767});
    idle();
    drain();

    send('{-32768, -32768, -32768, -32768, 32767, 0}, '{-32768, -32768, 0, 0});
    idle();
    drain();

    // Back-to-back burst: random vectors then a known nonzero tail.
    for (int i = 0; i < 10; i++) begin
      v = '{r16(), r16(), r16(), r16(), r16(), r16()};
      send(v, model(v));
    end
    v = '{100, 200, 50, 60, 32767, 0};
    send(v, '{150, 260, 50, 140});
    idle();
    drain();
    repeat (2) @(negedge clk);
    check("hold_valid", longint'(bus.valid), 0);
    check_outputs("hold", last_exp);

    // Reset while a result sits in stage 1: it must never emerge.
    @(negedge clk);
    apply('{1000, 1000, -1000, 500, 32767, 0});
    bus.enable = 1'b1;
    @(posedge clk);
    #2;
    bus.enable = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", longint'(bus.valid), 0);
    check_outputs("async_rst", zero);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_valid", longint'(bus.valid), 0);
    check_outputs("post_rst", zero);
    check("pulse_count", longint'(pulses), longint'(sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
